// File: rtl/spi_config_rx_pkg.sv
// spi_config_rx_pkg: synth config layout, status byte and FSM state types for the SPI config receiver.
package spi_config_rx_pkg;
  localparam int N_OSCILLATORS = 32;
  typedef struct packed {
    logic        env_reset;
    logic [6:0]  level;
    logic [7:0]  wave;
    logic [15:0] freq;
  } osc_t;
  typedef osc_t [N_OSCILLATORS-1:0] synth_t;
  localparam int SYNTH_BITS = $bits(synth_t);
  localparam int OSC_BITS = $bits(osc_t);
  localparam int ENVELOPE_RESET_BIT = OSC_BITS - 1;
  function automatic logic [SYNTH_BITS-1:0] autoclear_mask();
    logic [SYNTH_BITS-1:0] m;
    m = '0;
    for (int n = 0; n < N_OSCILLATORS; n++) m[n*OSC_BITS+ENVELOPE_RESET_BIT] = 1'b1;
    return m;
  endfunction
  localparam logic [SYNTH_BITS-1:0] SYNTH_AUTOCLEAR = autoclear_mask();
  typedef struct packed {
    logic       err;
    logic       ovr;
    logic [5:0] cnt;
  } status_t;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV} state_t;
endpackage

// File: rtl/spi_config_rx_pin_sync.sv
// spi_config_rx_pin_sync: multi-flop synchroniser for one async pin with rise/fall detection.
module spi_config_rx_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_last;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sync <= '0;
      r_last <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_last <= r_sync[STAGES-1];
    end
  assign o_level = r_sync[STAGES-1];
  assign o_rise  = o_level & ~r_last;
  assign o_fall  = ~o_level & r_last;
endmodule

// File: rtl/spi_config_rx.sv
// spi_config_rx: receives one config frame per chip-select window, stages it and
// commits it to cfg on sample_tick, auto-clearing one-shot bits a tick later.
module spi_config_rx
  import spi_config_rx_pkg::*;
#(
  parameter int                  CFG_BITS       = SYNTH_BITS,
  parameter int                  SYNC_STAGES    = 2,
  parameter logic [CFG_BITS-1:0] AUTOCLEAR_MASK = '0,
  parameter logic [CFG_BITS-1:0] CFG_RESET      = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic                spi_clk,
  input  logic                spi_csn,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic [CFG_BITS-1:0] cfg,
  output logic                cfg_valid,
  output logic                frame_err,
  output logic                overrun,
  output logic [7:0]          frame_count
);
  localparam int BW = $clog2(CFG_BITS + 2);
  localparam logic [BW-1:0] FULL = BW'(CFG_BITS);
  localparam logic [BW-1:0] SAT = BW'(CFG_BITS + 1);
  logic w_clk, w_clk_rise, w_clk_fall, w_csn, w_csn_rise, w_csn_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall, w_unused;
  logic w_start, w_end, w_good, w_commit;
  state_t r_state, w_next;
  status_t w_status;
  logic [BW-1:0] r_cnt;
  logic [CFG_BITS-1:0] r_shift, r_staged, r_cfg;
  logic [7:0] r_msh, r_count;
  logic r_miso, r_pending, r_clr, r_valid, r_frame_err, r_overrun;
  spi_config_rx_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .i_pin(spi_clk), .o_level(w_clk), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
  );
  spi_config_rx_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_csn (
    .clk(clk), .rst(rst), .i_pin(spi_csn), .o_level(w_csn), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );
  spi_config_rx_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_pin(spi_mosi), .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );
  assign w_unused = w_clk ^ w_mosi_rise ^ w_mosi_fall;
  assign w_status = '{err: r_frame_err, ovr: r_overrun, cnt: r_count[5:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= WAIT_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_start  = r_state == IDLE && w_csn_fall;
    w_end    = r_state == RECV && w_csn_rise;
    w_good   = w_end && r_cnt == FULL;
    w_commit = sample_tick && r_pending;
    w_next   = (r_state == WAIT_IDLE && w_csn) ? IDLE :
               w_start ? RECV :
               w_end ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_staged    <= '0;
      r_cfg       <= CFG_RESET;
      r_msh       <= '0;
      r_count     <= '0;
      r_miso      <= 1'b0;
      r_pending   <= 1'b0;
      r_clr       <= 1'b0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt <= '0;
        r_msh <= w_status;
      end
      if (r_state == RECV && w_clk_rise) begin
        r_shift <= {w_mosi, r_shift[CFG_BITS-1:1]};
        r_cnt   <= (r_cnt == SAT) ? r_cnt : r_cnt + BW'(1);
      end
      if (r_state != RECV) r_miso <= 1'b0;
      else if (w_clk_fall) begin
        r_miso <= r_msh[7];
        r_msh  <= {r_msh[6:0], 1'b0};
      end
      r_valid <= w_commit;
      if (w_commit) begin
        r_cfg     <= r_staged;
        r_count   <= r_count + 8'd1;
        r_pending <= 1'b0;
        r_clr     <= 1'b1;
      end else if (sample_tick && r_clr) begin
        r_cfg <= r_cfg & ~AUTOCLEAR_MASK;
        r_clr <= 1'b0;
      end
      // a frame landing on a commit tick re-arms pending after the old frame commits
      if (w_good) begin
        r_staged    <= r_shift;
        r_pending   <= 1'b1;
        r_frame_err <= 1'b0;
        if (r_pending) r_overrun <= 1'b1;
      end else if (w_end) r_frame_err <= 1'b1;
    end
  assign spi_miso    = r_miso & (r_state == RECV);
  assign cfg         = r_cfg;
  assign cfg_valid   = r_valid;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign frame_count = r_count;
endmodule

// File: doc/spi_config_rx.md
Name: spi_config_rx

Overview:
Parametrised successor to the control unit's SPI front end. It receives one configuration frame per chip-select window, entirely in the `clk` domain, using synchronised and oversampled SPI pins. It checks the frame length, stages a good frame, and commits it to the `cfg` output only on a `sample_tick`. After each commit it auto-clears designated one-shot command bits (e.g. envelope reset) on the following tick. It also returns a status byte on MISO.

Parameters:
- CFG_BITS, 1024: frame and config width in bits. The top level sets it to $bits(synth_t).
- SYNC_STAGES, 2: synchroniser depth on spi_clk, spi_csn and spi_mosi (minimum 2).
- AUTOCLEAR_MASK, '0: CFG_BITS-wide mask of bits cleared one tick after each commit.
- CFG_RESET, '0: reset value of `cfg`.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sample_tick  input  1  one-`clk` strobe per audio sample, already in the `clk` domain
- spi_clk  input  1  SPI clock (mode 0), asynchronous
- spi_csn  input  1  SPI chip select, active low, asynchronous
- spi_mosi  input  1  SPI data in; LSB of the frame first
- spi_miso  output  1  status byte out, MSB first
- cfg  output  CFG_BITS  committed configuration
- cfg_valid  output  1  one-cycle pulse on the commit cycle
- frame_err  output  1  sticky flag: a frame with the wrong length was received; cleared by reset or by a good frame
- overrun  output  1  sticky flag: a staged frame was replaced before it was committed; cleared by reset only
- frame_count  output  8  count of committed frames, wraps 255->0

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous and active-high.
- Reset values:
  - cfg = CFG_RESET
  - cfg_valid, frame_err, overrun, spi_miso = 0
  - frame_count = 0
  - staged and shift registers = 0
  - pending and clear_pending = 0
  - FSM = WAIT_IDLE
- Input synchronisation: all three SPI pins pass through SYNC_STAGES flops. Edge detection compares the last stage with one extra flop.
- Sampling requirement: SPI clock must not exceed f_clk/8. Sampling latency is SYNC_STAGES+1 cycles.
- FSM WAIT_IDLE: wait for synchronised csn = 1, then go to IDLE. This prevents accepting a partial frame when reset releases mid-frame.
- FSM IDLE: on csn falling edge, clear bit_cnt, load the MISO shifter with {frame_err, overrun, frame_count[5:0]}, and go to RECV.
- FSM RECV, each spi_clk rising edge:
  - shift = {mosi, shift[CFG_BITS-1:1]}, so the first bit lands at LSB.
  - bit_cnt += 1, saturating at CFG_BITS+1. Width is $clog2(CFG_BITS+2).
- FSM RECV, each spi_clk falling edge: spi_miso takes the next status bit. After 8 bits it drives 0. It is 0 whenever the FSM is not in RECV.
- FSM RECV, csn rising edge:
  - If bit_cnt == CFG_BITS: staged <= shift, set pending. If pending was already set, also set overrun. Clear frame_err.
  - Otherwise: set frame_err; staged and pending are unchanged.
  - Either way, go to IDLE.
- Commit: when sample_tick = 1 and pending = 1 at the start of the cycle:
  - cfg <= staged, cfg_valid = 1 for that cycle, frame_count += 1.
  - pending <= 0, clear_pending <= 1.
- Auto-clear: when sample_tick = 1, clear_pending = 1 and no commit occurs in that cycle: cfg <= cfg & ~AUTOCLEAR_MASK, clear_pending <= 0.
- Simultaneous events:
  - Frame completes in the same cycle as sample_tick: staged is written, and the commit waits for the next tick. pending is evaluated before the update.
  - Commit and auto-clear due on the same tick: commit wins and clear_pending stays 1. The new frame's one-shot bits therefore live for exactly one tick interval.
  - csn falling edge and csn rising edge never coincide. A glitch shorter than the sync depth is ignored.
- Reset mid-frame: frame discarded, pending dropped, cfg back to CFG_RESET, then WAIT_IDLE.

Decomposition:
- protocol_pkg:
  - CFG_BITS localparam derived from synth_t.
  - AUTOCLEAR mask built from `ENVELOPE_RESET_BIT for each of `N_OSCILLATORS.
  - status_t packed struct {err, ovr, cnt[5:0]}.
- Sub-module spi_pin_sync (SYNC_STAGES flops plus rise/fall detect), instantiated three times.
- FSM, shifter and commit logic stay in spi_config_rx.

Test Plan:
Bench settings: CFG_BITS=16, AUTOCLEAR_MASK=16'h0100, SPI at f_clk/8, sample_tick every 64 cycles.
1. Send 16 bits of 16'hA5C3, LSB first, then raise csn. Required: cfg stays CFG_RESET until the next tick. On that tick cfg=16'hA5C3, cfg_valid pulses once, frame_count=1.
2. Send 16'h01FF. Required: cfg=16'h01FF at the commit tick, then 16'h00FF at the following tick.
3. Send a 15-bit frame, then a 17-bit frame. Required: frame_err=1, cfg unchanged, frame_count unchanged. A following good 16-bit frame clears frame_err.
4. Send two good frames (16'h1111 then 16'h2222) between ticks. Required: overrun=1 and the tick commits 16'h2222 only.
5. After one good commit, read the status byte during the next frame. Required: spi_miso = 8'b00000001 MSB first, then 0 for the remaining bits.
6. Assert rst at bit 9 of a frame while csn stays low, release, finish the frame. Required: no commit, cfg=CFG_RESET. The next full frame commits normally.
